// File: rtl/scroll_pkg.sv
// scroll_pkg: shared encodings and wrap arithmetic for the scroll engine
// Contents:
//   speed_e  - speed select encodings (SPD_STOP, SPD_QUARTER, SPD_HALF, SPD_FULL)
//   state_e  - redraw FSM encodings (IDLE, DRAW, DRAIN)
//   wrap_add - (value + delta) mod modulus, for operands already below modulus
package scroll_pkg;

    typedef enum logic [1:0] {
        SPD_STOP    = 2'd0,
        SPD_QUARTER = 2'd1,
        SPD_HALF    = 2'd2,
        SPD_FULL    = 2'd3
    } speed_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // A single conditional subtraction is enough because both operands
    // are always below the modulus.
    function automatic int wrap_add(input int value, input int delta, input int modulus);
        return (value + delta >= modulus) ? value + delta - modulus : value + delta;
    endfunction

endpackage

// File: rtl/scroll_engine_if.sv
// scroll_engine_if: pixel stream and background ROM signals of the scroll engine
// Signals:
//   rom_addr - ROM read address (engine -> ROM)
//   rom_data - ROM colour, valid one cycle after rom_addr (ROM -> engine)
//   x, y     - pixel coordinates (engine -> vga_adapter)
//   colour   - pixel colour (engine -> vga_adapter)
//   plot     - pixel write strobe (engine -> vga_adapter)
// Modports: master = scroll engine side, slave = ROM / vga_adapter side.
interface scroll_engine_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int ADDR_W  = 15,
    parameter int COLOR_W = 3
) ();

    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_data;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic [COLOR_W-1:0] colour;
    logic               plot;

    modport master (
        output rom_addr, x, y, colour, plot,
        input  rom_data
    );

    modport slave (
        input  rom_addr, x, y, colour, plot,
        output rom_data
    );

endinterface

// File: rtl/scroll_rate_gen.sv
// scroll_rate_gen: base tick counter and speed divider producing scroll events
// Ports:
//   CLOCK_50   in  system clock
//   resetn     in  asynchronous active-low reset
//   speed      in  2-bit speed select (speed_e encoding)
//   scroll_evt out one-cycle scroll event strobe
module scroll_rate_gen
    import scroll_pkg::*;
#(
    parameter int TICK_CYCLES = 6250000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [1:0] speed,
    output logic       scroll_evt
);

    localparam int CW = $clog2(TICK_CYCLES + 1);

    logic [CW-1:0] tick_cnt;
    logic [1:0]    div;
    logic [1:0]    div_eff;
    logic [1:0]    speed_q;
    logic          tick;
    logic          chg;

    // On a speed change the divider is treated as already restarted, so a
    // tick landing in that same cycle is judged against the new rate.
    always_comb begin
        tick       = tick_cnt == CW'(TICK_CYCLES - 1);
        chg        = speed != speed_q;
        div_eff    = chg ? 2'd0 : div;
        scroll_evt = tick && (speed == SPD_FULL ||
                              (speed == SPD_HALF && div_eff[0]) ||
                              (speed == SPD_QUARTER && div_eff == 2'd3));
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tick_cnt <= '0;
            div      <= 2'd0;
            speed_q  <= SPD_STOP;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            div      <= div_eff + {1'b0, tick && speed != SPD_STOP};
            speed_q  <= speed;
        end
    end

endmodule

// File: rtl/scroll_engine.sv
// scroll_engine: vertical scroll engine redrawing the screen from a background ROM
// Ports:
//   CLOCK_50   in  system clock
//   resetn     in  asynchronous active-low reset
//   speed      in  0 stop, 1 every 4 base ticks, 2 every 2, 3 every tick
//   dir        in  0 offset increments, 1 decrements (SCROLL_REVERSE_EN only)
//   bus        master modport: rom_addr/rom_data, x/y/colour/plot
//   offset     out current scroll offset
//   frame_done out one-cycle pulse after the final plot of a frame
// Build option: define SCROLL_REVERSE_EN to honour dir; otherwise the offset
// always increments and the decrement path is not built.
module scroll_engine
    import scroll_pkg::*;
#(
    parameter int XSCREEN     = 160,
    parameter int YSCREEN     = 120,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int ADDR_W      = 15,
    parameter int COLOR_W     = 3,
    parameter int TICK_CYCLES = 6250000,
    parameter int STEP        = 1
) (
    input  logic             CLOCK_50,
    input  logic             resetn,
    input  logic [1:0]       speed,
    input  logic             dir,
    scroll_engine_if.master  bus,
    output logic [Y_W-1:0]   offset,
    output logic             frame_done
);

    state_e         state;
    state_e         state_nxt;
    logic           pending;
    logic           pending_nxt;
    logic           scroll_evt;
    logic           go;
    logic           x_end;
    logic           y_end;
    logic           last_px;
    logic [X_W-1:0] x_cnt;
    logic [Y_W-1:0] y_cnt;
    logic [Y_W-1:0] frame_off;
    logic [Y_W-1:0] off_inc;
    logic [Y_W-1:0] off_step;
    logic [Y_W-1:0] off_nxt;
    logic [X_W-1:0] x_d;
    logic [Y_W-1:0] y_d;
    logic           v_d;
    logic           last_d;
    logic           last_dd;

    scroll_rate_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_rate (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .speed     (speed),
        .scroll_evt(scroll_evt)
    );

    assign off_inc = Y_W'(wrap_add(int'(offset), STEP, YSCREEN));

`ifdef SCROLL_REVERSE_EN
    // Borrow out of the extra top bit marks a negative result.
    logic [Y_W:0] off_dec;
    assign off_dec  = {1'b0, offset} - (Y_W + 1)'(STEP);
    assign off_step = !dir ? off_inc :
                      off_dec[Y_W] ? Y_W'(off_dec + (Y_W + 1)'(YSCREEN)) : off_dec[Y_W-1:0];
`else
    logic unused_dir;
    assign unused_dir = dir;
    assign off_step   = off_inc;
`endif

    assign off_nxt = scroll_evt ? off_step : offset;
    assign go      = scroll_evt || pending;
    assign x_end   = x_cnt == X_W'(XSCREEN - 1);
    assign y_end   = y_cnt == Y_W'(YSCREEN - 1);
    assign last_px = state == DRAW && x_end && y_end;

    // Address follows the counters combinationally so the synchronous ROM
    // returns the pixel one cycle later, alongside x_d/y_d.
    always_comb begin
        bus.rom_addr = ADDR_W'(wrap_add(int'(y_cnt), int'(frame_off), YSCREEN) * XSCREEN + int'(x_cnt));
    end

    // Events arriving while busy collapse into one pending redraw.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        unique case (state)
            IDLE: begin
                state_nxt   = go ? DRAW : IDLE;
                pending_nxt = 1'b0;
            end
            DRAW: begin
                state_nxt   = last_px ? DRAIN : DRAW;
                pending_nxt = go;
            end
            DRAIN: begin
                state_nxt   = go ? DRAW : IDLE;
                pending_nxt = 1'b0;
            end
            default: begin
                state_nxt   = IDLE;
                pending_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state      <= DRAW;
            pending    <= 1'b0;
            offset     <= '0;
            frame_off  <= '0;
            x_cnt      <= '0;
            y_cnt      <= '0;
            x_d        <= '0;
            y_d        <= '0;
            v_d        <= 1'b0;
            last_d     <= 1'b0;
            last_dd    <= 1'b0;
            bus.x      <= '0;
            bus.y      <= '0;
            bus.colour <= '0;
            bus.plot   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            offset     <= off_nxt;
            frame_off  <= (state_nxt == DRAW && state != DRAW) ? off_nxt : frame_off;
            x_cnt      <= (state == DRAW && !x_end) ? x_cnt + 1'b1 : '0;
            y_cnt      <= state != DRAW ? '0 : x_end ? (y_end ? '0 : y_cnt + 1'b1) : y_cnt;
            x_d        <= x_cnt;
            y_d        <= y_cnt;
            v_d        <= state == DRAW;
            last_d     <= last_px;
            last_dd    <= last_d;
            bus.x      <= x_d;
            bus.y      <= y_d;
            bus.colour <= bus.rom_data;
            bus.plot   <= v_d;
            frame_done <= last_dd;
        end
    end

endmodule
